color_perm_detector: RTL and testbench

- Parametrised successor of the 3-colour ball sequence detector.
- Watches a stream of colour symbols and asserts a Mealy detect when the last NUM_COLORS valid symbols are all distinct, in any order.
- Selectable overlap or non-overlap mode, input qualifier, illegal-code handling, registered detect copy and saturating detection counter.
- Sits between the colour-sensor decoder and the sorter/statistics logic.

---
 rtl/color_det_pkg.sv | 27 ++
 rtl/color_perm_detector_sat_counter.sv | 26 ++
 rtl/color_perm_detector.sv | 91 +++++++++
 tb/tb_color_perm_detector.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/color_det_pkg.sv
// Shared definitions for the colour permutation detector: width helpers,
// canonical colour codes and window-mode constants.
package color_det_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Ages and run length both range 0..num_colors inclusive.
  function automatic int unsigned age_width(input int unsigned num_colors);
    return clog2(num_colors + 1);
  endfunction

  localparam int unsigned GC = 0;
  localparam int unsigned BC = 1;
  localparam int unsigned RC = 2;

  localparam int unsigned DEF_NUM_COLORS = 3;
  localparam int unsigned AGE_W          = age_width(DEF_NUM_COLORS);

  localparam int unsigned MODE_NON_OVERLAP = 0;
  localparam int unsigned MODE_OVERLAP     = 1;

endpackage

// File: rtl/color_perm_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/color_perm_detector.sv
// Detects when the last NUM_COLORS valid colour symbols are all distinct,
// tracking per-colour age and the length of the current distinct suffix.
module color_perm_detector
  import color_det_pkg::*;
#(
  parameter int unsigned NUM_COLORS = 3,
  parameter int unsigned SYM_W      = 2,
  parameter int unsigned OVERLAP    = MODE_NON_OVERLAP,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] inp,
  input  logic             inp_valid,
  input  logic             clr_cnt,
  output logic             det,
  output logic             det_q,
  output logic [CNT_W-1:0] det_cnt
);

  localparam int unsigned   AW         = age_width(NUM_COLORS);
  localparam logic [AW-1:0] FULL       = AW'(NUM_COLORS);
  localparam bit            CLR_ON_DET = (OVERLAP == MODE_NON_OVERLAP);

  logic [AW-1:0] r_age [NUM_COLORS];
  logic [AW-1:0] r_run;
  logic          r_det_q;

  logic [AW-1:0] w_age_s;
  logic [AW-1:0] w_run_nxt;
  logic          w_legal;
  logic          w_det;

  // Mealy decode: suffix length after accepting the current symbol.
  always_comb begin
    w_legal   = (32'(inp) < NUM_COLORS);
    w_age_s   = FULL;
    w_run_nxt = '0;
    for (int unsigned c = 0; c < NUM_COLORS; c++) begin
      if (inp == SYM_W'(c)) w_age_s = r_age[c];
    end
    if (w_age_s < r_run) begin
      w_run_nxt = w_age_s + AW'(1);
    end else if (r_run == FULL) begin
      w_run_nxt = FULL;
    end else begin
      w_run_nxt = r_run + AW'(1);
    end
    w_det = rst && inp_valid && w_legal && (w_run_nxt == FULL);
  end

  // History update; an illegal code or a non-overlap hit restarts the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < NUM_COLORS; c++) r_age[c] <= FULL;
      r_run   <= '0;
      r_det_q <= 1'b0;
    end else begin
      r_det_q <= w_det;
      if (inp_valid) begin
        if (!w_legal || (CLR_ON_DET && w_det)) begin
          for (int unsigned c = 0; c < NUM_COLORS; c++) r_age[c] <= FULL;
          r_run <= '0;
        end else begin
          for (int unsigned c = 0; c < NUM_COLORS; c++) begin
            if (inp == SYM_W'(c)) begin
              r_age[c] <= '0;
            end else if (r_age[c] != FULL) begin
              r_age[c] <= r_age[c] + AW'(1);
            end
          end
          r_run <= w_run_nxt;
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_det_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (w_det),
    .cnt (det_cnt)
  );

  assign det   = w_det;
  assign det_q = r_det_q;

endmodule

// File: tb/tb_color_perm_detector.sv
// Self-checking bench: four detector configurations share one stimulus stream
// and are compared against a history-queue reference model.
module tb_color_perm_detector;
  import color_det_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       inp_valid;
  logic       clr_cnt;
  logic [2:0] tb_inp;

  logic       det_w  [4];
  logic       detq_w [4];
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;

  int n_run  = 0;
  int n_fail = 0;

  int nc   [4] = '{3, 3, 3, 4};
  bit ov   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int cmax [4] = '{255, 255, 3, 255};

  int hist    [4][$];
  int exp_q   [4];
  int exp_cnt [4];

  always #5 clk = ~clk;

  color_perm_detector #(.NUM_COLORS(3), .SYM_W(2), .OVERLAP(MODE_NON_OVERLAP), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .inp(tb_inp[1:0]), .inp_valid(inp_valid), .clr_cnt(clr_cnt),
    .det(det_w[0]), .det_q(detq_w[0]), .det_cnt(cnt0));
  color_perm_detector #(.NUM_COLORS(3), .SYM_W(2), .OVERLAP(MODE_OVERLAP), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .inp(tb_inp[1:0]), .inp_valid(inp_valid), .clr_cnt(clr_cnt),
    .det(det_w[1]), .det_q(detq_w[1]), .det_cnt(cnt1));
  color_perm_detector #(.NUM_COLORS(3), .SYM_W(2), .OVERLAP(MODE_NON_OVERLAP), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .inp(tb_inp[1:0]), .inp_valid(inp_valid), .clr_cnt(clr_cnt),
    .det(det_w[2]), .det_q(detq_w[2]), .det_cnt(cnt2));
  color_perm_detector #(.NUM_COLORS(4), .SYM_W(3), .OVERLAP(MODE_OVERLAP), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .inp(tb_inp), .inp_valid(inp_valid), .clr_cnt(clr_cnt),
    .det(det_w[3]), .det_q(detq_w[3]), .det_cnt(cnt3));

  function automatic logic [7:0] act_cnt(input int i);
    case (i)
      0:       return cnt0;
      1:       return cnt1;
      2:       return {6'b0, cnt2};
      default: return cnt3;
    endcase
  endfunction

  function automatic int sym_of(input int i);
    return (i == 3) ? int'(tb_inp) : int'(tb_inp[1:0]);
  endfunction

  // Reference: detect iff the last nc symbols since the last restart are distinct.
  function automatic bit model_det(input int i);
    int w[$];
    int s;
    if (!inp_valid) return 1'b0;
    s = sym_of(i);
    if (s >= nc[i]) return 1'b0;
    w = hist[i];
    w.push_back(s);
    if (w.size() < nc[i]) return 1'b0;
    for (int a = w.size() - nc[i]; a < w.size(); a++)
      for (int b = a + 1; b < w.size(); b++)
        if (w[a] == w[b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, i, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist[i].delete();
      exp_q[i]   = 0;
      exp_cnt[i] = 0;
    end
  endtask

  task automatic step(input int s, input bit v, input bit clr);
    bit e[4];
    int si;
    tb_inp    = 3'(s);
    inp_valid = v;
    clr_cnt   = clr;
    #1;
    for (int i = 0; i < 4; i++) begin
      e[i] = model_det(i);
      check("det", i, 32'(det_w[i]), 32'(e[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (v) begin
        si = sym_of(i);
        if (si >= nc[i]) begin
          hist[i].delete();
        end else begin
          hist[i].push_back(si);
          if (e[i] && !ov[i]) hist[i].delete();
          else if (hist[i].size() > 8) void'(hist[i].pop_front());
        end
      end
      exp_q[i] = int'(e[i]);
      if (clr) exp_cnt[i] = 0;
      else if (e[i] && exp_cnt[i] < cmax[i]) exp_cnt[i]++;
      check("det_q", i, 32'(detq_w[i]), 32'(exp_q[i]));
      check("det_cnt", i, 32'(act_cnt(i)), 32'(exp_cnt[i]));
    end
  endtask

  task automatic flush();
    step(7, 1'b1, 1'b0);
  endtask

  initial begin
    int s;
    rst = 1'b0; tb_inp = 3'(GC); inp_valid = 1'b1; clr_cnt = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      check("rst_det", i, 32'(det_w[i]), 32'd0);
      check("rst_det_q", i, 32'(detq_w[i]), 32'd0);
      check("rst_cnt", i, 32'(act_cnt(i)), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    // G,B,R,G,B,R: non-overlap hits on 3 and 6, overlap hits on 3..6
    step(GC, 1, 0); step(BC, 1, 0); step(RC, 1, 0);
    step(GC, 1, 0); step(BC, 1, 0); step(RC, 1, 0);
    flush();
    // repeats
    step(GC, 1, 0); step(BC, 1, 0); step(BC, 1, 0); step(RC, 1, 0); step(GC, 1, 0);
    flush();
    // illegal code in the middle
    step(GC, 1, 0); step(BC, 1, 0); step(3, 1, 0);
    step(RC, 1, 0); step(GC, 1, 0); step(BC, 1, 0);
    flush();
    // invalid-cycle gap
    step(GC, 1, 0); step(RC, 0, 0); step(BC, 1, 0); step(RC, 1, 0);
    flush();
    // clear coincident with a detect
    step(GC, 1, 0); step(BC, 1, 0); step(RC, 1, 1);
    flush();
    // four more detections to saturate the 2-bit counter
    for (int k = 0; k < 4; k++) begin
      step(GC, 1, 0); step(BC, 1, 0); step(RC, 1, 0);
    end
    flush();
    // four-colour window
    step(0, 1, 0); step(1, 1, 0); step(2, 1, 0); step(3, 1, 0); step(0, 1, 0);
    flush();

    // asynchronous reset between edges
    step(GC, 1, 0); step(BC, 1, 0);
    tb_inp = 3'(RC); inp_valid = 1'b1; clr_cnt = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("midrst_det", i, 32'(det_w[i]), 32'd0);
      check("midrst_det_q", i, 32'(detq_w[i]), 32'd0);
      check("midrst_cnt", i, 32'(act_cnt(i)), 32'd0);
    end
    model_reset();
    #1;
    rst = 1'b1;
    step(RC, 1, 0);

    // randomized stream, mostly legal symbols
    for (int k = 0; k < 400; k++) begin
      s = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
      step(s, ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
